crc8_stream: RTL and testbench

Byte-serial CRC-8 engine. It folds one 8-bit byte per clock into a running CRC register whenever valid is high, and restarts from the initial value on start. It sits under a packet or controller FSM that issues a start pulse and then streams bytes. The final checksum is read from crc_out after the last valid byte.

---
 rtl/crc8_stream.sv | 70 +++++++
 tb/tb_crc8_stream.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/crc8_stream.sv
// crc8_stream: byte-serial CRC-8 engine, one byte folded per clock.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous active-high reset, loads INIT
//   start    one-cycle pulse restarting the CRC from INIT
//   valid    byte_in is folded into the CRC on this edge
//   byte_in  data byte
//   crc_out  (REFOUT ? rev8(crc_q) : crc_q) ^ XOROUT, combinational from crc_q
module crc8_stream #(
  parameter logic [7:0] POLY   = 8'h07,
  parameter logic [7:0] INIT   = 8'h00,
  parameter bit         REFIN  = 1'b0,
  parameter bit         REFOUT = 1'b0,
  parameter logic [7:0] XOROUT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       valid,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] fold_base;
  logic [7:0] fold_res;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Eight shift/reduce steps unrolled so a whole byte folds in one cycle;
  // the shift drops bit 8, which is the implicit x^8 term.
  function automatic logic [7:0] fold(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ (REFIN ? rev8(b) : b);
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ POLY) : (x << 1);
    end
    return x;
  endfunction

  // A start with valid begins the new message with this byte, so fold from INIT.
  assign fold_base = start ? INIT : crc_q;
  assign fold_res  = fold(fold_base, byte_in);

  always_comb begin
    crc_d = crc_q;
    if (valid) begin
      crc_d = fold_res;
    end else if (start) begin
      crc_d = INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = (REFOUT ? rev8(crc_q) : crc_q) ^ XOROUT;

endmodule

// File: tb/tb_crc8_stream.sv
module tb_crc8_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] byte_in;
  logic [7:0] crc_a;
  logic [7:0] crc_b;

  always #5 clk = ~clk;

  // Default configuration (CRC-8/SMBUS-like).
  crc8_stream u_dut_a (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .byte_in(byte_in), .crc_out(crc_a)
  );

  // Reflected configuration (CRC-8/MAXIM), fed the same stimulus.
  crc8_stream #(
    .POLY(8'h31), .INIT(8'h00), .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(8'h00)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .byte_in(byte_in), .crc_out(crc_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ma, mb;
  logic       model_live = 1'b0;

  function automatic logic [7:0] rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Bit-serial polynomial division: feed message bits one at a time into
  // the remainder (MSB of the byte first, or LSB first when reflected).
  function automatic logic [7:0] ref_step(input logic [7:0] c, input logic [7:0] b,
                                          input logic [7:0] poly, input bit refin);
    logic [7:0] r;
    logic       msg_bit;
    logic       fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      msg_bit = refin ? b[i] : b[7-i];
      fb      = r[7] ^ msg_bit;
      r       = {r[6:0], 1'b0};
      if (fb) r = r ^ poly;
    end
    return r;
  endfunction

  function automatic logic [7:0] out_a(input logic [7:0] c);
    return c;
  endfunction

  function automatic logic [7:0] out_b(input logic [7:0] c);
    return rev(c);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] b);
    @(negedge clk);
    rst     = r;
    start   = s;
    valid   = v;
    byte_in = v ? b : 8'hxx;
    if (r) begin
      ma = 8'h00;
      mb = 8'h00;
    end else if (s && v) begin
      ma = ref_step(8'h00, b, 8'h07, 1'b0);
      mb = ref_step(8'h00, b, 8'h31, 1'b1);
    end else if (s) begin
      ma = 8'h00;
      mb = 8'h00;
    end else if (v) begin
      ma = ref_step(ma, b, 8'h07, 1'b0);
      mb = ref_step(mb, b, 8'h31, 1'b1);
    end
    qa.push_back(out_a(ma));
    qb.push_back(out_b(mb));
  endtask

  // Checks a known value just after the edge that applies the last drive.
  task automatic expect_a(input string name, input logic [7:0] exp);
    @(posedge clk);
    #2;
    check(name, crc_a, exp);
  endtask

  task automatic expect_b(input string name, input logic [7:0] exp);
    @(posedge clk);
    #2;
    check(name, crc_b, exp);
  endtask

  // Monitor: after every edge, compare each DUT against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) check("scoreboard_a", crc_a, qa.pop_front());
      if (qb.size() > 0) check("scoreboard_b", crc_b, qb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [7:0] check_str[9];

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; byte_in = 8'h00;
    ma = 8'h00; mb = 8'h00;
    for (int i = 0; i < 9; i++) check_str[i] = 8'h31 + 8'(i);

    // Reset with valid and 0xFF present must hold the INIT value.
    drive(1, 0, 1, 8'hFF); expect_a("reset_1", 8'h00);
    drive(1, 0, 1, 8'hFF); expect_a("reset_2", 8'h00);
    drive(0, 0, 0, 8'h00); expect_a("idle_after_reset", 8'h00);
    drive(0, 0, 0, 8'h00); expect_b("idle_after_reset_b", 8'h00);

    // Single bytes.
    drive(0, 1, 0, 8'h00); drive(0, 0, 1, 8'h01); expect_a("byte_01", 8'h07);
    drive(0, 1, 0, 8'h00); drive(0, 0, 1, 8'h00); expect_a("byte_00", 8'h00);
    drive(0, 1, 0, 8'h00); drive(0, 0, 1, 8'hFF); expect_a("byte_ff", 8'hF3);

    // Sequence, then restart with no bytes.
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 1, 8'h01); expect_a("seq_first", 8'h07);
    drive(0, 0, 1, 8'h02); expect_a("seq_second", 8'h1B);
    drive(0, 1, 0, 8'h00); expect_a("restart_empty", 8'h00);

    // Check string back-to-back.
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, check_str[i]);
    expect_a("check_string", 8'hF4);
    drive(0, 0, 0, 8'h00); expect_b("check_string_maxim", 8'hA1);

    // Check string with idle gaps; the scoreboard confirms the hold in gaps.
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, check_str[i]);
      repeat (i % 3) drive(0, 0, 0, 8'h00);
    end
    expect_a("check_string_gaps", 8'hF4);

    // Start together with a byte mid-message discards the partial CRC.
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 1, 8'hA5);
    drive(0, 0, 1, 8'h3C);
    drive(0, 1, 1, 8'h01); expect_a("start_with_byte", 8'h07);

    // Reset mid-message.
    drive(0, 0, 1, 8'h77);
    drive(1, 0, 1, 8'h55); expect_a("reset_mid_msg", 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7),
            8'($urandom));
    end

    drive(0, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    check("queue_drained", 8'(qa.size() + qb.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
